dmem_responder: RTL

- Multi-cycle data-memory responder (target side) for the pipeline's Memory-stage load/store port.
- Accepts one request at a time over a valid/ready handshake and returns read data or a write acknowledge after a programmable latency.
- Drives `stall` back to the pipeline while a request is outstanding.
- Replaces the zero-latency data memory so the pipeline can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef logic [31:0] word_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic word_t be_merge(input word_t old_w, input word_t new_w,
                                     input logic [WORD_BYTES-1:0] be);
    word_t r;
    r = old_w;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response channel between the pipeline Memory stage and the responder.
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// Word RAM: synchronous byte-enabled write, combinational read, contents never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  word_t                 i_wdata,
  input  logic [WORD_BYTES-1:0] i_be,
  output word_t                 o_rdata
);

  word_t r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= be_merge(r_mem[i_addr], i_wdata, i_be);
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with programmable latency and pipeline stall.
// Define DMEM_PERF_CNT_EN to add req_count/err_count performance counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter word_t       BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_if.slave       bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] req_count,
  output logic [31:0] err_count
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

  dmem_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  word_t       r_rdata;
  logic        r_err;

  word_t       w_offset;
  logic        w_err;
  logic        w_accept;
  logic        w_we;
  word_t       w_rd;

  // Range check is done on a 33-bit compare so SPAN itself never wraps.
  assign w_offset = bus.req_addr - BASE_ADDR;
  assign w_err    = (bus.req_addr[1:0] != 2'b00) || ({1'b0, w_offset} >= SPAN);
  assign w_accept = bus.req_valid && r_req_ready;
  assign w_we     = w_accept && bus.req_write && !w_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_offset[AW+1:2]),
    .i_wdata (bus.req_wdata),
    .i_be    (bus.req_be),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_err       <= w_err;
            r_rdata     <= (bus.req_write || w_err) ? '0 : w_rd;
            r_cnt       <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  // Releasing in the handshake cycle lets the pipeline advance on the same edge the response retires.
  assign bus.stall      = ((r_state != IDLE) || bus.req_valid)
                          && !((r_state == RESP) && bus.resp_ready);

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_req_count;
  logic [31:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_count <= '0;
      r_err_count <= '0;
    end else if (w_accept) begin
      r_req_count <= r_req_count + 32'd1;
      if (w_err) r_err_count <= r_err_count + 32'd1;
    end
  end

  assign req_count = r_req_count;
  assign err_count = r_err_count;
`endif

endmodule
